// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between execute and a single-ported data memory.
// Optional bus-timeout trap enabled by defining LSU_TIMEOUT_EN.
module lsu_mem_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_trap,
    output logic [2:0]  o_trap_cause,
    output logic        o_mem_req,
    input  logic        i_mem_gnt,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R, RESP} state_t;

    state_t      state_q, state_nx;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [2:0]  cause_q;
    logic [2:0]  cause_dec;
    logic        accept;
    logic        tmo_fire;

    // Illegal funct3 outranks misalignment; 0 means the access may proceed.
    function automatic logic [2:0] decode_cause(input logic we, input logic [2:0] f3,
                                                input logic [1:0] off);
        logic legal;
        logic mis;
        if (we)
            legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        else
            legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                    (f3 == 3'b100) || (f3 == 3'b101);
        case (f3[1:0])
            2'b01:   mis = off[0];
            2'b10:   mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        if (!legal)
            decode_cause = 3'd3;
        else if (mis)
            decode_cause = we ? 3'd2 : 3'd1;
        else
            decode_cause = 3'd0;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] wdata);
        case (f3[1:0])
            2'b00:   store_data = 32'(wdata[7:0]) << {off, 3'b000};
            2'b01:   store_data = 32'(wdata[15:0]) << {off[1], 4'b0000};
            default: store_data = wdata;
        endcase
    endfunction

    function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   store_mask = ~(4'b0001 << off);
            2'b01:   store_mask = off[1] ? 4'b0011 : 4'b1100;
            default: store_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rdata);
        logic        [31:0] word;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] r;
        word = rdata >> {off, 3'b000};
        b    = word[7:0];
        h    = word[15:0];
        case (f3)
            3'b000:  r = b;
            3'b001:  r = h;
            3'b100:  r = {24'd0, word[7:0]};
            3'b101:  r = {16'd0, word[15:0]};
            default: r = word;
        endcase
        load_ext = r;
    endfunction

    assign accept    = (state_q == IDLE) && i_req_valid;
    assign cause_dec = decode_cause(i_we, i_funct3, i_addr[1:0]);

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] cnt_q;
    logic             tmo;

    assign tmo      = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign tmo_fire = tmo && (((state_q == ISSUE) && !i_mem_gnt) ||
                              ((state_q == WAIT_R) && !i_mem_rvalid));

    // Counter restarts on every state change, so ISSUE and WAIT_R each get a full budget.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            cnt_q <= '0;
        else if (state_nx != state_q)
            cnt_q <= '0;
        else if ((state_q == ISSUE) || (state_q == WAIT_R))
            cnt_q <= cnt_q + 1'b1;
    end
`else
    assign tmo_fire = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            state_q <= IDLE;
        else
            state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        case (state_q)
            IDLE: begin
                if (i_req_valid)
                    state_nx = (cause_dec != 3'd0) ? RESP : ISSUE;
            end
            ISSUE: begin
                if (i_mem_gnt)
                    state_nx = o_mem_we ? RESP : WAIT_R;
                else if (tmo_fire)
                    state_nx = RESP;
            end
            WAIT_R: begin
                if (i_mem_rvalid || tmo_fire)
                    state_nx = RESP;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = 1'b0;
        o_mem_req   = 1'b0;
        o_done      = 1'b0;
        o_trap      = 1'b0;
        case (state_q)
            IDLE:  o_req_ready = 1'b1;
            ISSUE: o_mem_req   = 1'b1;
            RESP: begin
                o_done = 1'b1;
                o_trap = (cause_q != 3'd0);
            end
            default: ;
        endcase
    end

    assign o_trap_cause = cause_q;

    // Memory-side fields only change on a legal accept, so they stay stable until grant.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            f3_q        <= 3'd0;
            off_q       <= 2'd0;
            cause_q     <= 3'd0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= 32'd0;
            o_mem_wdata <= 32'd0;
            o_mem_mask  <= 4'b1111;
            o_rdata     <= 32'd0;
        end else begin
            if (accept) begin
                f3_q    <= i_funct3;
                off_q   <= i_addr[1:0];
                cause_q <= cause_dec;
                if (cause_dec == 3'd0) begin
                    o_mem_we    <= i_we;
                    o_mem_addr  <= {i_addr[31:2], 2'b00};
                    o_mem_wdata <= i_we ? store_data(i_funct3, i_addr[1:0], i_wdata) : 32'd0;
                    o_mem_mask  <= i_we ? store_mask(i_funct3, i_addr[1:0]) : 4'b1111;
                end
            end
            if ((state_q == WAIT_R) && i_mem_rvalid)
                o_rdata <= load_ext(f3_q, off_q, i_mem_rdata);
            if (tmo_fire)
                cause_q <= 3'd4;
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl; covers stores, loads, traps, back-to-back and reset abort.
module tb_lsu_mem_ctrl;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_we;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_done;
    logic [31:0] o_rdata;
    logic        o_trap;
    logic [2:0]  o_trap_cause;
    logic        o_mem_req;
    logic        i_mem_gnt;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_mask;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;

    int errors = 0;
    int checks = 0;

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_we(i_we), .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_done(o_done), .o_rdata(o_rdata), .o_trap(o_trap), .o_trap_cause(o_trap_cause),
        .o_mem_req(o_mem_req), .i_mem_gnt(i_mem_gnt), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask),
        .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        i_req_valid = 1'b1;
        i_we        = we;
        i_funct3    = f3;
        i_addr      = addr;
        i_wdata     = wdata;
    endtask

    initial begin
        i_rst_n = 1'b0; i_req_valid = 1'b0; i_we = 1'b0; i_funct3 = 3'd0;
        i_addr = 32'd0; i_wdata = 32'd0; i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
        i_mem_rdata = 32'd0;
        step(); step();
        chk("rst_ready", o_req_ready, 1);
        chk("rst_req", o_mem_req, 0);
        chk("rst_mask", o_mem_mask, 4'b1111);
        chk("rst_done", o_done, 0);
        chk("rst_rdata", o_rdata, 0);
        chk("rst_addr", o_mem_addr, 0);
        i_rst_n = 1'b1;
        step();

        // SB at byte 3
        drive(1'b1, 3'b000, 32'h0000_1003, 32'hA5A5_A5C3);
        step();
        i_req_valid = 1'b0;
        chk("sb_req", o_mem_req, 1);
        chk("sb_we", o_mem_we, 1);
        chk("sb_addr", o_mem_addr, 32'h0000_1000);
        chk("sb_mask", o_mem_mask, 4'b0111);
        chk("sb_wdata", o_mem_wdata, 32'hC300_0000);
        chk("sb_ready", o_req_ready, 0);
        chk("sb_done_early", o_done, 0);
        i_mem_gnt = 1'b1;
        step();
        i_mem_gnt = 1'b0;
        chk("sb_done", o_done, 1);
        chk("sb_trap", o_trap, 0);
        chk("sb_req_drop", o_mem_req, 0);
        step();
        chk("sb_done_pulse", o_done, 0);
        chk("sb_idle", o_req_ready, 1);

        // LB with grant delayed three cycles
        drive(1'b0, 3'b000, 32'h0000_2002, 32'h0);
        step();
        i_req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("lb_hold_req", o_mem_req, 1);
            chk("lb_hold_addr", o_mem_addr, 32'h0000_2000);
            chk("lb_hold_mask", o_mem_mask, 4'b1111);
            if (k < 3) step();
        end
        i_mem_gnt = 1'b1;
        step();
        i_mem_gnt = 1'b0;
        chk("lb_req_drop", o_mem_req, 0);
        chk("lb_wait_nodone", o_done, 0);
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'h0080_0000;
        step();
        i_mem_rvalid = 1'b0;
        chk("lb_done", o_done, 1);
        chk("lb_rdata", o_rdata, 32'hFFFF_FF80);
        step();

        // LBU, grant immediately
        drive(1'b0, 3'b100, 32'h0000_2002, 32'h0);
        step();
        i_req_valid = 1'b0;
        i_mem_gnt = 1'b1;
        step();
        i_mem_gnt = 1'b0;
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'h0080_0000;
        step();
        i_mem_rvalid = 1'b0;
        chk("lbu_done", o_done, 1);
        chk("lbu_trap", o_trap, 0);
        chk("lbu_rdata", o_rdata, 32'h0000_0080);
        step();

        // Traps: LW misaligned, SH misaligned, illegal store funct3
        drive(1'b0, 3'b010, 32'h0000_3002, 32'h0);
        step();
        i_req_valid = 1'b0;
        chk("lw_mis_done", o_done, 1);
        chk("lw_mis_trap", o_trap, 1);
        chk("lw_mis_cause", o_trap_cause, 3'd1);
        chk("lw_mis_noreq", o_mem_req, 0);
        step();
        chk("lw_mis_noreq2", o_mem_req, 0);
        chk("lw_mis_trap_pulse", o_trap, 0);
        drive(1'b1, 3'b001, 32'h0000_3001, 32'h0);
        step();
        i_req_valid = 1'b0;
        chk("sh_mis_trap", o_trap, 1);
        chk("sh_mis_cause", o_trap_cause, 3'd2);
        step();
        drive(1'b1, 3'b100, 32'h0000_3000, 32'h0);
        step();
        i_req_valid = 1'b0;
        chk("st_ill_trap", o_trap, 1);
        chk("st_ill_cause", o_trap_cause, 3'd3);
        chk("st_ill_noreq", o_mem_req, 0);
        chk("trap_rdata_kept", o_rdata, 32'h0000_0080);
        step();

        // Back-to-back SW then LH
        drive(1'b1, 3'b010, 32'h0000_4000, 32'h1122_3344);
        step();
        chk("sw_mask", o_mem_mask, 4'b0000);
        chk("sw_wdata", o_mem_wdata, 32'h1122_3344);
        drive(1'b0, 3'b001, 32'h0000_4002, 32'h0);
        i_mem_gnt = 1'b1;
        step();
        i_mem_gnt = 1'b0;
        chk("sw_done", o_done, 1);
        chk("sw_busy", o_req_ready, 0);
        step();
        chk("sw_rdata_kept", o_rdata, 32'h0000_0080);
        chk("b2b_ready", o_req_ready, 1);
        step();
        i_req_valid = 1'b0;
        chk("lh_req", o_mem_req, 1);
        chk("lh_we", o_mem_we, 0);
        chk("lh_addr", o_mem_addr, 32'h0000_4000);
        i_mem_gnt = 1'b1;
        step();
        i_mem_gnt = 1'b0;
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'h8001_1234;
        step();
        i_mem_rvalid = 1'b0;
        chk("lh_done", o_done, 1);
        chk("lh_rdata", o_rdata, 32'hFFFF_8001);
        step();

        // Reset in the middle of ISSUE
        drive(1'b0, 3'b010, 32'h0000_5000, 32'h0);
        step();
        i_req_valid = 1'b0;
        chk("mid_req", o_mem_req, 1);
        i_rst_n = 1'b0;
        step(); step();
        chk("mid_rst_req", o_mem_req, 0);
        chk("mid_rst_mask", o_mem_mask, 4'b1111);
        chk("mid_rst_ready", o_req_ready, 1);
        i_rst_n = 1'b1;
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'hDEAD_BEEF;
        step();
        i_mem_rvalid = 1'b0;
        chk("late_rvalid_done", o_done, 0);
        step();
        chk("late_rvalid_done2", o_done, 0);
        chk("late_rvalid_rdata", o_rdata, 0);

        // Grant withheld
        drive(1'b1, 3'b010, 32'h0000_6000, 32'h0);
        step();
        i_req_valid = 1'b0;
`ifdef LSU_TIMEOUT_EN
        for (int k = 0; k < 15; k++) step();
        chk("tmo_req_c16", o_mem_req, 1);
        chk("tmo_trap_c16", o_trap, 0);
        step();
        chk("tmo_req_drop", o_mem_req, 0);
        chk("tmo_done", o_done, 1);
        chk("tmo_trap", o_trap, 1);
        chk("tmo_cause", o_trap_cause, 3'd4);
        step();
`else
        for (int k = 0; k < 100; k++) step();
        chk("notmo_req", o_mem_req, 1);
        chk("notmo_done", o_done, 0);
        i_mem_gnt = 1'b1;
        step();
        i_mem_gnt = 1'b0;
        chk("notmo_late_done", o_done, 1);
        chk("notmo_late_trap", o_trap, 0);
        step();
`endif
        chk("end_ready", o_req_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
